sid_filter_sched: RTL and testbench

//  Sequencer for the shared sid_filter datapath, time-multiplexing one filter between two SID chips.
//  On each SID-cycle enable it runs two 8-step passes, chip 0 then chip 1, and generates the filter's state code.
//  It muxes the active chip's registers and voices onto the filter inputs and captures each chip's audio result.

---
 rtl/sid_filter_sched.sv | 121 ++++++++++++
 tb/tb_sid_filter_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sid_filter_sched.sv
// Sequences the shared sid_filter through an 8-step pass for chip 0, then chip 1, on every ce_1m.
// Mux outputs are combinational from registered chip select; audio is captured at the end of step 6.
// ce_1m is accepted when idle or on the final edge of a pair; otherwise it is ignored and overrun pulses.
module sid_filter_sched #(
    parameter bit DUAL = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce_1m,
    input  logic               mode_0,
    input  logic               mode_1,
    input  logic [15:0]        f0_0,
    input  logic [15:0]        f0_1,
    input  logic [7:0]         res_filt_0,
    input  logic [7:0]         res_filt_1,
    input  logic [7:0]         mode_vol_0,
    input  logic [7:0]         mode_vol_1,
    input  logic signed [21:0] v1_0,
    input  logic signed [21:0] v2_0,
    input  logic signed [21:0] v3_0,
    input  logic signed [21:0] ext_0,
    input  logic signed [21:0] v1_1,
    input  logic signed [21:0] v2_1,
    input  logic signed [21:0] v3_1,
    input  logic signed [21:0] ext_1,
    output logic [2:0]         flt_state,
    output logic               flt_mode,
    output logic [15:0]        flt_f0,
    output logic [7:0]         flt_res_filt,
    output logic [7:0]         flt_mode_vol,
    output logic signed [21:0] flt_v1,
    output logic signed [21:0] flt_v2,
    output logic signed [21:0] flt_v3,
    output logic signed [21:0] flt_ext,
    input  logic [17:0]        flt_audio,
    output logic [17:0]        audio_0,
    output logic [17:0]        audio_1,
    output logic               sample_0,
    output logic               sample_1,
    output logic               busy,
    output logic               overrun
);

    logic       chip;
    logic [2:0] step;
    logic       last;

    assign last      = busy && chip && (step == 3'd7);
    assign flt_state = step;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= 1'b0;
            chip     <= 1'b0;
            step     <= 3'd0;
            audio_0  <= 18'd0;
            audio_1  <= 18'd0;
            sample_0 <= 1'b0;
            sample_1 <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            sample_0 <= 1'b0;
            sample_1 <= 1'b0;
            overrun  <= ce_1m && busy && !last;
            if (ce_1m && (!busy || last)) begin
                busy <= 1'b1;
                chip <= 1'b0;
                step <= 3'd0;
            end else if (last) begin
                busy <= 1'b0;
                chip <= 1'b0;
                step <= 3'd0;
            end else if (busy) begin
                {chip, step} <= {chip, step} + 4'd1;
            end
            // Filter output for the active chip is valid throughout step 6
            if (busy && (step == 3'd6)) begin
                if (!chip) begin
                    audio_0  <= flt_audio;
                    sample_0 <= 1'b1;
                end else begin
                    audio_1  <= DUAL ? flt_audio : 18'd0;
                    sample_1 <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        flt_mode     = mode_0;
        flt_f0       = f0_0;
        flt_res_filt = res_filt_0;
        flt_mode_vol = mode_vol_0;
        flt_v1       = v1_0;
        flt_v2       = v2_0;
        flt_v3       = v3_0;
        flt_ext      = ext_0;
        if (chip) begin
            if (DUAL) begin
                flt_mode     = mode_1;
                flt_f0       = f0_1;
                flt_res_filt = res_filt_1;
                flt_mode_vol = mode_vol_1;
                flt_v1       = v1_1;
                flt_v2       = v2_1;
                flt_v3       = v3_1;
                flt_ext      = ext_1;
            end else begin
                // Single-chip build still runs the chip-1 pass to keep filter state pairing
                flt_f0       = 16'd0;
                flt_res_filt = 8'd0;
                flt_mode_vol = 8'd0;
                flt_v1       = 22'sd0;
                flt_v2       = 22'sd0;
                flt_v3       = 22'sd0;
                flt_ext      = 22'sd0;
            end
        end
    end

endmodule

// File: tb/tb_sid_filter_sched.sv
// Directed bench for sid_filter_sched: one DUAL=1 and one DUAL=0 instance share all inputs.
module tb_sid_filter_sched;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ce_1m = 1'b0;
    logic mode_0 = 1'b1, mode_1 = 1'b0;
    logic [15:0] f0_0 = 16'h1234, f0_1 = 16'h5678;
    logic [7:0] res_filt_0 = 8'hA1, res_filt_1 = 8'hB2;
    logic [7:0] mode_vol_0 = 8'h0F, mode_vol_1 = 8'h05;
    logic signed [21:0] v1_0 = 22'h000011, v2_0 = 22'h000022, v3_0 = 22'h000033, ext_0 = 22'h000044;
    logic signed [21:0] v1_1 = 22'h1FFFFF, v2_1 = 22'h000066, v3_1 = 22'h000077, ext_1 = 22'h000088;
    logic [17:0] flt_audio = 18'h00123;

    logic [2:0] flt_state, d0_flt_state;
    logic flt_mode, d0_flt_mode;
    logic [15:0] flt_f0, d0_flt_f0;
    logic [7:0] flt_res_filt, d0_flt_res_filt, flt_mode_vol, d0_flt_mode_vol;
    logic signed [21:0] flt_v1, flt_v2, flt_v3, flt_ext;
    logic signed [21:0] d0_flt_v1, d0_flt_v2, d0_flt_v3, d0_flt_ext;
    logic [17:0] audio_0, audio_1, d0_audio_0, d0_audio_1;
    logic sample_0, sample_1, busy, overrun;
    logic d0_sample_0, d0_sample_1, d0_busy, d0_overrun;

    always #5 clk = ~clk;

    sid_filter_sched #(.DUAL(1'b1)) dut (
        .clk(clk), .reset(reset), .ce_1m(ce_1m),
        .mode_0(mode_0), .mode_1(mode_1), .f0_0(f0_0), .f0_1(f0_1),
        .res_filt_0(res_filt_0), .res_filt_1(res_filt_1),
        .mode_vol_0(mode_vol_0), .mode_vol_1(mode_vol_1),
        .v1_0(v1_0), .v2_0(v2_0), .v3_0(v3_0), .ext_0(ext_0),
        .v1_1(v1_1), .v2_1(v2_1), .v3_1(v3_1), .ext_1(ext_1),
        .flt_state(flt_state), .flt_mode(flt_mode), .flt_f0(flt_f0),
        .flt_res_filt(flt_res_filt), .flt_mode_vol(flt_mode_vol),
        .flt_v1(flt_v1), .flt_v2(flt_v2), .flt_v3(flt_v3), .flt_ext(flt_ext),
        .flt_audio(flt_audio), .audio_0(audio_0), .audio_1(audio_1),
        .sample_0(sample_0), .sample_1(sample_1), .busy(busy), .overrun(overrun)
    );

    sid_filter_sched #(.DUAL(1'b0)) dut0 (
        .clk(clk), .reset(reset), .ce_1m(ce_1m),
        .mode_0(mode_0), .mode_1(mode_1), .f0_0(f0_0), .f0_1(f0_1),
        .res_filt_0(res_filt_0), .res_filt_1(res_filt_1),
        .mode_vol_0(mode_vol_0), .mode_vol_1(mode_vol_1),
        .v1_0(v1_0), .v2_0(v2_0), .v3_0(v3_0), .ext_0(ext_0),
        .v1_1(v1_1), .v2_1(v2_1), .v3_1(v3_1), .ext_1(ext_1),
        .flt_state(d0_flt_state), .flt_mode(d0_flt_mode), .flt_f0(d0_flt_f0),
        .flt_res_filt(d0_flt_res_filt), .flt_mode_vol(d0_flt_mode_vol),
        .flt_v1(d0_flt_v1), .flt_v2(d0_flt_v2), .flt_v3(d0_flt_v3), .flt_ext(d0_flt_ext),
        .flt_audio(flt_audio), .audio_0(d0_audio_0), .audio_1(d0_audio_1),
        .sample_0(d0_sample_0), .sample_1(d0_sample_1), .busy(d0_busy), .overrun(d0_overrun)
    );

    typedef struct {
        logic [2:0]  st;
        logic        bsy;
        logic [7:0]  mv;
        logic        md;
        logic        s0;
        logic        s1;
        logic [17:0] a0;
        logic [17:0] a1;
        logic [21:0] d0_v1;
    } vec_t;

    vec_t vec [1:17];
    int checks = 0;
    int errors = 0;
    int ov_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Single pair expectations, cycles 1..17 after a ce_1m in cycle 0
        for (int c = 1; c <= 17; c++) begin
            vec[c].st    = (c <= 16) ? 3'((c - 1) % 8) : 3'd0;
            vec[c].bsy   = (c <= 16);
            vec[c].mv    = (c >= 9 && c <= 16) ? 8'h05 : 8'h0F;
            vec[c].md    = (c >= 9 && c <= 16) ? 1'b0 : 1'b1;
            vec[c].s0    = (c == 8);
            vec[c].s1    = (c == 16);
            vec[c].a0    = (c >= 8) ? 18'h00123 : 18'h0;
            vec[c].a1    = (c >= 16) ? 18'h00456 : 18'h0;
            vec[c].d0_v1 = (c >= 9 && c <= 16) ? 22'h0 : 22'h000011;
        end

        nxt;
        nxt;
        chk("reset flt_state", 32'(flt_state), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset audio_0", 32'(audio_0), 0);
        chk("reset audio_1", 32'(audio_1), 0);
        chk("reset samples", {30'd0, sample_0, sample_1}, 0);
        chk("reset overrun", 32'(overrun), 0);
        chk("reset chip sel", 32'(flt_mode_vol), 32'h0F);
        reset = 1'b0;

        // Table: single pair with per-pass audio
        nxt;
        ce_1m = 1'b1;
        flt_audio = 18'h00123;
        for (int c = 1; c <= 17; c++) begin
            nxt;
            ce_1m = 1'b0;
            flt_audio = (c <= 8) ? 18'h00123 : 18'h00456;
            #1;
            chk($sformatf("flt_state c%0d", c), 32'(flt_state), 32'(vec[c].st));
            chk($sformatf("busy c%0d", c), 32'(busy), 32'(vec[c].bsy));
            chk($sformatf("mode_vol c%0d", c), 32'(flt_mode_vol), 32'(vec[c].mv));
            chk($sformatf("flt_mode c%0d", c), 32'(flt_mode), 32'(vec[c].md));
            chk($sformatf("sample_0 c%0d", c), 32'(sample_0), 32'(vec[c].s0));
            chk($sformatf("sample_1 c%0d", c), 32'(sample_1), 32'(vec[c].s1));
            chk($sformatf("audio_0 c%0d", c), 32'(audio_0), 32'(vec[c].a0));
            chk($sformatf("audio_1 c%0d", c), 32'(audio_1), 32'(vec[c].a1));
            chk($sformatf("overrun c%0d", c), 32'(overrun), 0);
            chk($sformatf("d0 flt_v1 c%0d", c), 32'(d0_flt_v1), 32'(vec[c].d0_v1));
            chk($sformatf("d0 flt_mode c%0d", c), 32'(d0_flt_mode), 1);
            chk($sformatf("d0 audio_1 c%0d", c), 32'(d0_audio_1), 0);
            chk($sformatf("d0 sample_1 c%0d", c), 32'(d0_sample_1), 32'(vec[c].s1));
            chk($sformatf("d0 flt_state c%0d", c), 32'(d0_flt_state), 32'(vec[c].st));
        end

        // Overrun: ce_1m at cycles 0 and 5
        nxt;
        ce_1m = 1'b1;
        ov_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            nxt;
            ce_1m = (c == 5);
            #1;
            if (overrun) ov_cnt++;
            if (c == 6) begin
                chk("overrun pulse c6", 32'(overrun), 1);
                chk("overrun flt_state c6", 32'(flt_state), 5);
            end
            if (c == 16) chk("overrun busy c16", 32'(busy), 1);
            if (c == 16) chk("overrun flt_state c16", 32'(flt_state), 7);
            if (c >= 17) chk($sformatf("overrun single pair c%0d", c), 32'(busy), 0);
        end
        chk("overrun pulse count", 32'(ov_cnt), 1);

        // Back-to-back: ce_1m at cycles 0 and 16
        nxt;
        ce_1m = 1'b1;
        ov_cnt = 0;
        for (int c = 1; c <= 34; c++) begin
            nxt;
            ce_1m = (c == 16);
            #1;
            if (overrun) ov_cnt++;
            if (c == 17) begin
                chk("b2b restart state", 32'(flt_state), 0);
                chk("b2b restart busy", 32'(busy), 1);
                chk("b2b restart chip", 32'(flt_mode_vol), 32'h0F);
            end
            if (c == 25) chk("b2b second chip1", 32'(flt_mode_vol), 32'h05);
            if (c == 32) chk("b2b last state", 32'(flt_state), 7);
            if (c == 33) chk("b2b idle", 32'(busy), 0);
        end
        chk("b2b overrun count", 32'(ov_cnt), 0);

        // Reset mid-pair in cycle 10
        flt_audio = 18'h00123;
        nxt;
        ce_1m = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            nxt;
            ce_1m = 1'b0;
            #1;
        end
        chk("pre-reset state c10", 32'(flt_state), 1);
        chk("pre-reset chip c10", 32'(flt_mode_vol), 32'h05);
        reset = 1'b1;
        #1;
        chk("midreset flt_state", 32'(flt_state), 0);
        chk("midreset busy", 32'(busy), 0);
        chk("midreset audio_0", 32'(audio_0), 0);
        chk("midreset audio_1", 32'(audio_1), 0);
        chk("midreset chip sel", 32'(flt_mode_vol), 32'h0F);
        nxt;
        ce_1m = 1'b1;
        nxt;
        ce_1m = 1'b0;
        #1;
        chk("ce during reset ignored", 32'(busy), 0);
        reset = 1'b0;
        nxt;
        chk("post-reset idle", 32'(busy), 0);
        ce_1m = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            nxt;
            ce_1m = 1'b0;
            #1;
            if (c == 1) begin
                chk("post-reset start state", 32'(flt_state), 0);
                chk("post-reset start chip0", 32'(flt_mode_vol), 32'h0F);
                chk("post-reset start busy", 32'(busy), 1);
            end
            if (c == 9) chk("post-reset chip1", 32'(flt_mode_vol), 32'h05);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
